// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds FSM states, requester ids and default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection between fetch and data requesters.
// Ports: clk, rst_n, arb_en_i (arbitration cycle), if_valid_i,
//   d_valid_i -> gnt_o (someone wins), win_o (winner id).
// With MEM_ARB_FAIRNESS_EN a starvation counter forces a fetch
// grant after STARVE_LIMIT data grants made while fetch waited.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   arb_en_i,
  input  logic   if_valid_i,
  input  logic   d_valid_i,
  output logic   gnt_o,
  output owner_e win_o
);

  assign gnt_o = arb_en_i & (if_valid_i | d_valid_i);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve;

  // Never exceeds the limit: at the limit with fetch waiting,
  // fetch wins and the count clears.
  assign starve = if_valid_i &&
                  (cnt_q == CW'(STARVE_LIMIT));

  always_comb begin
    win_o = OWN_IF;
    if (d_valid_i && !starve) begin
      win_o = OWN_D;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_o) begin
      if (win_o == OWN_IF) begin
        cnt_d = '0;
      end else if (if_valid_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_lim = STARVE_LIMIT;
  logic unused_sel;

  assign unused_sel = ^{clk, rst_n};
  assign win_o      = d_valid_i ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port,
// one outstanding transaction. Ports: clk, rst_n, if_req_*,
// if_rsp_*, d_req_*, d_rsp_*, mem_req_*, mem_rsp_*.
// Optional macro MEM_ARB_FAIRNESS_EN enables fetch anti-starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SW = DATA_W / 8;

  state_e          state_q, state_d;
  owner_e          own_q, own_d;
  owner_e          win;
  logic            gnt;
  logic            arb_en;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;

  // Gate with rst_n so no ready leaks out while reset is held.
  assign arb_en = rst_n && (state_q == IDLE);

  mem_arb_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en_i  (arb_en),
    .if_valid_i(if_req_valid),
    .d_valid_i (d_req_valid),
    .gnt_o     (gnt),
    .win_o     (win)
  );

  always_comb begin
    state_d       = state_q;
    own_d         = own_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    if_rsp_valid  = 1'b0;
    d_rsp_valid   = 1'b0;
    mem_req_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = REQ;
          own_d   = win;
          if (win == OWN_D) begin
            d_req_ready = 1'b1;
            addr_d      = d_addr;
            we_d        = d_we;
            wdata_d     = d_wdata;
            wstrb_d     = d_wstrb;
          end else begin
            if_req_ready = 1'b1;
            addr_d       = if_addr;
            we_d         = 1'b0;
            wdata_d      = '0;
            wstrb_d      = '0;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (own_q == OWN_D) begin
            d_rsp_valid = 1'b1;
          end else begin
            if_rsp_valid = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule
